// File: rtl/sram_arbiter_if.sv
// Purpose : bundles the instruction, data and shared-bus handshakes of the SRAM arbiter.
// Ports   : inst_* / data_* requester channels, bus_* shared port channel.
//           slave modport = arbiter view, master modport = environment view.
interface sram_arbiter_if;
  // instruction requester
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  // data requester
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  // shared SRAM-like port
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport master (
    output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Purpose : arbitrates inst/data requesters onto one SRAM-like port, routes in-order responses back.
// Latency : zero-cycle request and response paths; grant is locked while the bus stalls addr_ok.
// Backpr. : at most OUTST_DEPTH accepted-but-unanswered transactions; no new grant while full
//           unless a response pops in the same cycle.
// Ports   : clk, reset (async, active-high), io (sram_arbiter_if.slave), resp_err (sticky,
//           response seen with nothing outstanding).
module sram_arbiter #(
  parameter int OUTST_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_arbiter_if.slave        io,
  output logic                 resp_err
);

  localparam int PTR_W = $clog2(OUTST_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t                 state, next_state;
  logic [OUTST_DEPTH-1:0] src_q;      // 1 = data, 0 = inst
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [SC_W-1:0]        starve_cnt;

  logic grant_i, grant_d;
  logic full, push, pop, head;

  assign full = (count == CNT_W'(OUTST_DEPTH));
  assign head = src_q[rd_ptr];
  // Responses only pop when something is outstanding; stray ones only flag resp_err.
  assign pop  = io.bus_data_ok && (count != '0) && !reset;

  // Grant selection and next state. A pop in the same cycle frees a slot, so a
  // full FIFO does not block the grant in that cycle.
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (!full || pop) begin
            if (starve_cnt == SC_W'(STARVE_LIMIT) && io.inst_req) grant_i = 1'b1;
            else if (io.data_req)                                grant_d = 1'b1;
            else if (io.inst_req)                                grant_i = 1'b1;
          end
          if ((grant_i || grant_d) && !io.bus_addr_ok)
            next_state = grant_d ? HOLD_D : HOLD_I;
        end
        HOLD_I: begin
          grant_i = 1'b1;
          if (io.bus_addr_ok) next_state = IDLE;
        end
        HOLD_D: begin
          grant_d = 1'b1;
          if (io.bus_addr_ok) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  assign push = (grant_i || grant_d) && io.bus_addr_ok;

  assign io.bus_req   = grant_i || grant_d;
  assign io.bus_wr    = grant_d ? io.data_wr    : io.inst_wr;
  assign io.bus_size  = grant_d ? io.data_size  : io.inst_size;
  assign io.bus_wstrb = grant_d ? io.data_wstrb : io.inst_wstrb;
  assign io.bus_addr  = grant_d ? io.data_addr  : io.inst_addr;
  assign io.bus_wdata = grant_d ? io.data_wdata : io.inst_wdata;

  assign io.inst_addr_ok = grant_i && io.bus_addr_ok;
  assign io.data_addr_ok = grant_d && io.bus_addr_ok;
  assign io.inst_data_ok = pop && !head;
  assign io.data_data_ok = pop &&  head;
  assign io.inst_rdata   = io.bus_rdata;
  assign io.data_rdata   = io.bus_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      src_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= next_state;
      // When full with a same-cycle pop, wr_ptr==rd_ptr: the head was already
      // consumed combinationally, so overwriting it here is safe.
      if (push) begin
        src_q[wr_ptr] <= grant_d;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (io.bus_data_ok && count == '0) resp_err <= 1'b1;
      if (grant_i && io.bus_addr_ok)
        starve_cnt <= '0;
      else if (state == IDLE && io.inst_req && grant_d && starve_cnt != SC_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Purpose : self-checking bench for sram_arbiter: directed scenarios plus random traffic,
//           every cycle compared against a queue-based reference model.
// Ports   : none (top-level bench).
module tb_sram_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk;
  logic reset;
  logic resp_err;

  sram_arbiter_if sif ();

  sram_arbiter #(.OUTST_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .io       (sif.slave),
    .resp_err (resp_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: outstanding sources in order (0 = inst, 1 = data),
  // the requester a stalled grant is locked to (-1 = none), starvation count, error flag.
  int q[$];
  int lock   = -1;
  int starve = 0;
  bit err    = 1'b0;
  int m_win;
  bit m_pop, m_iok, m_dok;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    sif.inst_req = 0; sif.inst_wr = 0; sif.inst_size = 0; sif.inst_wstrb = 0;
    sif.inst_addr = 0; sif.inst_wdata = 0;
    sif.data_req = 0; sif.data_wr = 0; sif.data_size = 0; sif.data_wstrb = 0;
    sif.data_addr = 0; sif.data_wdata = 0;
    sif.bus_addr_ok = 0; sif.bus_data_ok = 0; sif.bus_rdata = 0;
  endtask

  // Inputs are set by the caller just after a falling edge; settle() predicts and checks outputs.
  task automatic settle();
    bit hd;
    #1;
    m_win = -1;
    m_pop = sif.bus_data_ok && q.size() > 0 && !reset;
    hd    = m_pop ? (q[0] == 1) : 1'b0;
    if (!reset) begin
      if (lock >= 0) m_win = lock;
      else if (q.size() < DEPTH || m_pop) begin
        if (starve == LIMIT && sif.inst_req) m_win = 0;
        else if (sif.data_req)               m_win = 1;
        else if (sif.inst_req)               m_win = 0;
      end
    end
    m_iok = (m_win == 0) && sif.bus_addr_ok;
    m_dok = (m_win == 1) && sif.bus_addr_ok;
    chk("bus_req", sif.bus_req, m_win >= 0);
    if (m_win == 0) begin
      chk("bus_addr_i", sif.bus_addr, sif.inst_addr);
      chk("bus_ctl_i", {sif.bus_wr, sif.bus_size, sif.bus_wstrb, sif.bus_wdata},
          {sif.inst_wr, sif.inst_size, sif.inst_wstrb, sif.inst_wdata});
    end else if (m_win == 1) begin
      chk("bus_addr_d", sif.bus_addr, sif.data_addr);
      chk("bus_ctl_d", {sif.bus_wr, sif.bus_size, sif.bus_wstrb, sif.bus_wdata},
          {sif.data_wr, sif.data_size, sif.data_wstrb, sif.data_wdata});
    end
    chk("inst_addr_ok", sif.inst_addr_ok, m_iok);
    chk("data_addr_ok", sif.data_addr_ok, m_dok);
    chk("inst_data_ok", sif.inst_data_ok, m_pop && !hd);
    chk("data_data_ok", sif.data_data_ok, m_pop && hd);
    chk("rdata", {sif.inst_rdata, sif.data_rdata}, {sif.bus_rdata, sif.bus_rdata});
    chk("resp_err", resp_err, reset ? 1'b0 : err);
  endtask

  // Advance one clock and update the model with the inputs seen at that edge.
  task automatic adv();
    bit baok, bdok, ireq;
    baok = sif.bus_addr_ok; bdok = sif.bus_data_ok; ireq = sif.inst_req;
    @(posedge clk);
    if (reset) begin
      q.delete(); lock = -1; starve = 0; err = 0;
    end else begin
      if (bdok && q.size() == 0) err = 1;
      if (m_pop) void'(q.pop_front());
      if (m_win >= 0 && baok) q.push_back(m_win);
      if (lock < 0 && m_win == 1 && ireq && starve < LIMIT) starve++;
      if (m_win == 0 && baok) starve = 0;
      lock = (m_win >= 0 && !baok) ? m_win : -1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    settle();
    adv();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    @(negedge clk);
    // reset state
    settle();
    chk("rst_bus_req", sif.bus_req, 1'b0);
    adv();
    reset = 0;
    settle();
    chk("rst_starve", dut.starve_cnt, 0);
    adv();

    // priority: data wins a simultaneous request
    sif.inst_req = 1; sif.inst_addr = 32'h1000;
    sif.data_req = 1; sif.data_addr = 32'h2000; sif.bus_addr_ok = 1;
    settle();
    chk("prio_daok", sif.data_addr_ok, 1'b1);
    chk("prio_iaok", sif.inst_addr_ok, 1'b0);
    chk("prio_addr", sif.bus_addr, 32'h2000);
    adv();
    do_reset();

    // grant lock: inst stalled three cycles, data arrives in cycle 2
    sif.inst_req = 1; sif.inst_addr = 32'hA0; sif.data_addr = 32'hD0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) sif.data_req = 1;
      sif.bus_addr_ok = (c == 4);
      settle();
      chk("lock_addr", sif.bus_addr, 32'hA0);
      chk("lock_iaok", sif.inst_addr_ok, c == 4);
      adv();
    end
    sif.inst_req = 0;
    settle();
    chk("lock_then_d", sif.data_addr_ok, 1'b1);
    adv();
    do_reset();

    // ordering: inst, data, inst then three responses
    sif.bus_addr_ok = 1;
    sif.inst_req = 1; settle(); adv();
    sif.inst_req = 0; sif.data_req = 1; settle(); adv();
    sif.data_req = 0; sif.inst_req = 1; settle(); adv();
    sif.inst_req = 0; sif.bus_addr_ok = 0; sif.bus_data_ok = 1;
    sif.bus_rdata = 32'h11; settle();
    chk("ord1_iok", {sif.inst_data_ok, sif.data_data_ok, sif.inst_rdata}, {2'b10, 32'h11}); adv();
    sif.bus_rdata = 32'h22; settle();
    chk("ord2_dok", {sif.inst_data_ok, sif.data_data_ok, sif.data_rdata}, {2'b01, 32'h22}); adv();
    sif.bus_rdata = 32'h33; settle();
    chk("ord3_iok", {sif.inst_data_ok, sif.data_data_ok, sif.inst_rdata}, {2'b10, 32'h33}); adv();
    do_reset();

    // full: four accepts, fifth blocked until a response pops
    sif.data_req = 1; sif.bus_addr_ok = 1;
    for (int c = 0; c < 4; c++) begin
      sif.data_addr = 32'h100 + 32'(c);
      settle(); adv();
    end
    sif.data_addr = 32'h200;
    settle();
    chk("full_block", sif.bus_req, 1'b0);
    adv();
    sif.bus_data_ok = 1;
    settle();
    chk("full_pop_req", sif.bus_req, 1'b1);
    chk("full_pop_daok", sif.data_addr_ok, 1'b1);
    adv();
    do_reset();

    // anti-starvation: 8 data grants, then inst
    sif.inst_req = 1; sif.data_req = 1; sif.bus_addr_ok = 1;
    sif.inst_addr = 32'h44; sif.data_addr = 32'h88;
    for (int k = 0; k <= LIMIT; k++) begin
      sif.bus_data_ok = (k > 0);
      settle();
      chk("starve_win", {sif.inst_addr_ok, sif.data_addr_ok}, (k == LIMIT) ? 2'b10 : 2'b01);
      adv();
    end
    sif.inst_req = 0; sif.data_req = 0; sif.bus_addr_ok = 0; sif.bus_data_ok = 0;
    settle();
    chk("starve_clr", dut.starve_cnt, 0);
    adv();
    do_reset();

    // error flag and async reset mid HOLD_D
    sif.bus_data_ok = 1; settle(); adv();
    sif.bus_data_ok = 0; settle();
    chk("err_set", resp_err, 1'b1); adv();
    sif.data_req = 1; sif.data_addr = 32'hDD; settle();
    chk("err_hold", resp_err, 1'b1); adv();
    settle();
    chk("holdd_req", sif.bus_req, 1'b1);
    #3 reset = 1;
    #1;
    chk("arst_req", sif.bus_req, 1'b0);
    chk("arst_err", resp_err, 1'b0);
    chk("arst_daok", sif.data_addr_ok, 1'b0);
    adv();
    reset = 0;
    clear_inputs();
    settle(); adv();

    // random traffic against the model
    for (int c = 0; c < 800; c++) begin
      if (!sif.inst_req || m_iok) begin
        sif.inst_req = 1'($urandom_range(0, 1)); sif.inst_wr = 1'($urandom);
        sif.inst_size = 2'($urandom_range(0, 2)); sif.inst_wstrb = 4'($urandom);
        sif.inst_addr = $urandom; sif.inst_wdata = $urandom;
      end
      if (!sif.data_req || m_dok) begin
        sif.data_req = 1'($urandom_range(0, 1)); sif.data_wr = 1'($urandom);
        sif.data_size = 2'($urandom_range(0, 2)); sif.data_wstrb = 4'($urandom);
        sif.data_addr = $urandom; sif.data_wdata = $urandom;
      end
      sif.bus_addr_ok = 1'($urandom_range(0, 1));
      sif.bus_data_ok = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      sif.bus_rdata   = $urandom;
      settle();
      adv();
    end
    clear_inputs();
    settle();
    chk("rand_starve", dut.starve_cnt, 32'(starve));
    adv();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter OUTST_DEPTH, default 4: maximum accepted-but-unanswered bus transactions (power of 2, >=2).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8: consecutive inst-losing cycles before inst is forced to win.
REQ-003 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- inst_req / inst_wr  in  1/1  fetch request / write flag
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_wstrb  in  4  byte enables
- inst_addr / inst_wdata  in  32/32  address / write data
- inst_addr_ok / inst_data_ok  out  1/1  request accepted / response delivered
- inst_rdata  out  32  read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1,1,2,4,32,32  load/store request, same meaning as inst_*
- data_addr_ok / data_data_ok  out  1/1
- data_rdata  out  32
- bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata  out  1,1,2,4,32,32  shared port request
- bus_addr_ok / bus_data_ok  in  1/1  shared port accept / response
- bus_rdata  in  32  shared port read data
- resp_err  out  1  sticky: bus_data_ok seen with nothing outstanding

Function
REQ-004 The block SHALL keep an in-order source FIFO of OUTST_DEPTH 1-bit entries (1=data, 0=inst) with a count register; full = count==OUTST_DEPTH.
REQ-005 The block SHALL implement FSM states IDLE, HOLD_I, HOLD_D.
REQ-006 In IDLE, winner: inst if starve_cnt==STARVE_LIMIT and inst_req; else data if data_req; else inst if inst_req; no winner when full.
REQ-007 In IDLE with a winner, bus_req SHALL be 1 combinationally and bus_wr/size/wstrb/addr/wdata SHALL be the winner's inputs.
REQ-008 In IDLE with a winner and bus_addr_ok=0, the next state SHALL be HOLD_I or HOLD_D for the winner; with bus_addr_ok=1, it SHALL stay IDLE.
REQ-009 In HOLD_x, bus_req SHALL be 1 with fields from requester x regardless of the other requester; on bus_addr_ok it SHALL return to IDLE.
REQ-010 Requesters SHALL hold req and fields stable until their addr_ok; behaviour on violation is undefined.
REQ-011 x_addr_ok SHALL equal bus_addr_ok AND (bus_req granted to x); the non-granted requester's addr_ok SHALL be 0.
REQ-012 On bus_req & bus_addr_ok, the granted source SHALL be pushed into the FIFO at the clock edge.
REQ-013 On bus_data_ok with count>0, the FIFO head SHALL pop; data_data_ok = bus_data_ok & head==1 and inst_data_ok = bus_data_ok & head==0, combinationally (zero-cycle latency).
REQ-014 inst_rdata and data_rdata SHALL both equal bus_rdata combinationally.
REQ-015 On a same-cycle push and pop, count SHALL be unchanged, and the pop SHALL use the pre-push head.
REQ-016 On bus_data_ok with count==0, both data_ok outputs SHALL be 0, the FIFO SHALL be unchanged, and resp_err SHALL set and hold until reset.
REQ-017 starve_cnt SHALL increment (saturating at STARVE_LIMIT) in each IDLE cycle where inst_req=1 and data is granted.
REQ-018 starve_cnt SHALL clear when an inst request is accepted (inst_addr_ok=1); otherwise it holds.
REQ-019 When full, no new grant SHALL be issued (bus_req=0 in IDLE) until a pop occurs; HOLD_x cannot be entered while full.

Reset
REQ-020 Asserting reset SHALL immediately force: state=IDLE, count=0, FIFO pointers=0, starve_cnt=0, resp_err=0.
REQ-021 During reset, all outputs SHALL be 0 (bus_req, all addr_ok/data_ok, resp_err), including a reset asserted mid-HOLD or with responses outstanding; in-flight responses arriving after reset are treated per REQ-016.

Verification
REQ-022 Bench scenario, priority: inst_req=1 and data_req=1 in the same cycle, bus_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, bus_addr=data_addr.
REQ-023 Bench scenario, grant lock: inst granted, bus_addr_ok=0 for 3 cycles, data_req raised in cycle 2 -> bus_addr stays inst_addr for all 3 cycles; inst_addr_ok=1 in cycle 4.
REQ-024 Bench scenario, ordering: push inst, data, inst, then three bus_data_ok pulses with rdata 0x11, 0x22, 0x33 -> inst_data_ok/0x11, data_data_ok/0x22, inst_data_ok/0x33.
REQ-025 Bench scenario, full: 4 accepts with no responses -> 5th request sees bus_req=0; one bus_data_ok -> bus_req=1 the same cycle.
REQ-026 Bench scenario, anti-starvation: data_req and inst_req held at 1 with bus_addr_ok=1 -> 8 data grants, then 1 inst grant, then starve_cnt=0.
REQ-027 Bench scenario, error/reset: bus_data_ok with count 0 -> resp_err=1 next cycle and held; async reset pulse mid-HOLD_D -> bus_req=0 and resp_err=0 before the next clock edge.
